pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencing controller for the five-stage pipelined MIPS core. It generates the enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MM and MM/WB pipeline latches, including the MEM/WB latch. Inputs are cache hits, the MEM-stage memory request, load-use hazards, MEM-stage branch/jump redirects and halt. It also holds off duplicate dcache requests, latches the processor halt, and keeps stall/flush performance counters.

## Interface
- CNT_W, 32, width of the performance counters.

- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  icache hit for the current fetch.
- dhit  in  1  dcache access complete.
- mm_dREN  in  1  MEM-stage load request.
- mm_dWEN  in  1  MEM-stage store request.
- mm_halt  in  1  halt instruction is in MEM.
- mm_redirect  in  1  branch taken or jump resolved in MEM.
- ex_memread  in  1  EX-stage instruction is a load (MemtoReg selects load).
- ex_rd  in  5  EX-stage destination register.
- id_rs, id_rt  in  5 each  ID-stage source registers.
- dREN_out, dWEN_out  out  1 each  gated dcache requests.
- pc_en, ifid_en, idex_en, exmm_en, mmwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmm_flush  out  1 each  synchronous bubble insert.
- halt  out  1  registered processor halt.
- stall_cnt  out  CNT_W  stalled-cycle count.
- flush_cnt  out  CNT_W  redirect count.

## Operation
- States: RUN, MEMWAIT, HALTED. Reset state is RUN.
- dmem_done register: set on dhit when advance=0. Cleared on any advance.
- Gated requests: dREN_out = mm_dREN & ~dmem_done & ~HALTED. dWEN_out uses the same rule with mm_dWEN.
- mem_busy = (mm_dREN|mm_dWEN) & ~dhit & ~dmem_done.
- advance = ihit & ~mem_busy & (state != HALTED).
- load_use = ex_memread & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt).
- Outputs in priority order:
  1. HALTED: all enables and flushes 0.
  2. advance=0: all enables and flushes 0. The whole pipe holds.
  3. advance & mm_redirect: all enables 1. ifid_flush, idex_flush and exmm_flush are 1. Redirect beats load_use.
  4. advance & load_use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmm_en=1, mmwb_en=1.
  5. advance otherwise: all enables 1, flushes 0.
- Flushes are asserted only together with their latch enable.
- Transitions:
  - RUN→MEMWAIT when mem_busy.
  - MEMWAIT→RUN when dhit or dmem_done.
  - RUN or MEMWAIT→HALTED when advance & mm_halt.
  - HALTED exits only by reset.
- halt is set on entry to HALTED and is sticky.
- stall_cnt increments by 1 in each non-HALTED cycle with advance=0, or with rule 4 active. It saturates at all-ones.
- flush_cnt increments by 1 in each cycle with rule 3 active. It saturates at all-ones.

## Timing
- Enables, flushes and gated requests are combinational from inputs and registered state, with zero latency.
- state, dmem_done, halt and the counters update on the rising CLK edge.
- Reset values: state=RUN, dmem_done=0, halt=0, stall_cnt=0, flush_cnt=0.
- Combinational outputs follow the reset state immediately. With ihit=0, all enables are 0.
- nRST assertion mid-access clears dmem_done and the state at once. Requests re-issue from the MEM-stage inputs after release.
- dhit and ihit in the same cycle with no other hazard: advance=1, dmem_done stays 0.
- dhit while ihit=0: dmem_done=1 next cycle and dREN_out/dWEN_out drop to 0. Pipe advances on the first later ihit, and dmem_done clears on that edge.
- mm_halt with advance=0: no transition until advance.
- load_use and mm_redirect together: rule 3 applies. The load-use bubble is discarded with the flushed instructions.

## Test plan
- Reset, then ihit=1 with no hazards: all enables 1, flushes 0, halt=0, counters stay 0 over 10 cycles.
- mm_dREN=1 with ihit=1, dhit low for 3 cycles then 1: state MEMWAIT for 3 cycles, all enables 0 for those cycles, advance in cycle 4, stall_cnt=3.
- mm_dWEN=1 with dhit=1 and ihit=0, then ihit=1 two cycles later: dWEN_out drops the cycle after dhit, no second write is issued, advance on ihit, dmem_done returns to 0.
- ex_memread=1, ex_rd=5, id_rt=5, ihit=1: pc_en=0, ifid_en=0, idex_flush=1, mmwb_en=1, stall_cnt +1. Repeat with ex_rd=0: no stall.
- mm_redirect=1 with load_use=1 and ihit=1: all enables 1, three flushes 1, flush_cnt=1, stall_cnt unchanged.
- mm_halt=1 with advance: halt=1 next edge and all enables 0 thereafter. Then nRST low mid-HALTED: halt=0 asynchronously and state is RUN.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline sequencing controller and the MIPS datapath.
// The master side is the controller; the slave side is the datapath and caches.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             mm_dREN;
    logic             mm_dWEN;
    logic             mm_halt;
    logic             mm_redirect;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             dREN_out;
    logic             dWEN_out;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmm_en;
    logic             mmwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmm_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ihit, dhit, mm_dREN, mm_dWEN, mm_halt, mm_redirect,
        input  ex_memread, ex_rd, id_rs, id_rt,
        output dREN_out, dWEN_out,
        output pc_en, ifid_en, idex_en, exmm_en, mmwb_en,
        output ifid_flush, idex_flush, exmm_flush,
        output halt, stall_cnt, flush_cnt
    );

    modport slave (
        output ihit, dhit, mm_dREN, mm_dWEN, mm_halt, mm_redirect,
        output ex_memread, ex_rd, id_rs, id_rt,
        input  dREN_out, dWEN_out,
        input  pc_en, ifid_en, idex_en, exmm_en, mmwb_en,
        input  ifid_flush, idex_flush, exmm_flush,
        input  halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: latch enables/flushes, dcache request gating,
// sticky halt and saturating stall/redirect performance counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    pipeline_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             dmem_done_q, dmem_done_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic halted_s;
    logic mem_busy_s;
    logic advance_s;
    logic load_use_s;
    logic redirect_s;
    logic bubble_s;

    // Hazard and progress decode shared by outputs and next-state logic
    always_comb begin
        halted_s   = (state_q == HALTED);
        mem_busy_s = (bus.mm_dREN | bus.mm_dWEN) & ~bus.dhit & ~dmem_done_q;
        advance_s  = bus.ihit & ~mem_busy_s & ~halted_s;
        load_use_s = bus.ex_memread & (bus.ex_rd != 5'd0) &
                     ((bus.ex_rd == bus.id_rs) | (bus.ex_rd == bus.id_rt));
        redirect_s = advance_s & bus.mm_redirect;
        bubble_s   = advance_s & ~bus.mm_redirect & load_use_s;
    end

    // Latch enables and flushes; a redirect discards any load-use bubble
    always_comb begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_en    = 1'b0;
        bus.exmm_en    = 1'b0;
        bus.mmwb_en    = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.exmm_flush = 1'b0;
        if (halted_s || !advance_s) begin
            bus.pc_en = 1'b0;
        end else if (bus.mm_redirect) begin
            bus.pc_en      = 1'b1;
            bus.ifid_en    = 1'b1;
            bus.idex_en    = 1'b1;
            bus.exmm_en    = 1'b1;
            bus.mmwb_en    = 1'b1;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exmm_flush = 1'b1;
        end else if (load_use_s) begin
            bus.idex_en    = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exmm_en    = 1'b1;
            bus.mmwb_en    = 1'b1;
        end else begin
            bus.pc_en   = 1'b1;
            bus.ifid_en = 1'b1;
            bus.idex_en = 1'b1;
            bus.exmm_en = 1'b1;
            bus.mmwb_en = 1'b1;
        end
    end

    // A completed access is not re-issued while the pipe waits on the icache
    always_comb begin
        bus.dREN_out  = bus.mm_dREN & ~dmem_done_q & ~halted_s;
        bus.dWEN_out  = bus.mm_dWEN & ~dmem_done_q & ~halted_s;
        bus.halt      = halt_q;
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    // Next-state for the sequencer, completion flag, halt and counters
    always_comb begin
        state_d     = state_q;
        dmem_done_d = dmem_done_q;
        halt_d      = halt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            RUN: begin
                if (advance_s && bus.mm_halt) begin
                    state_d = HALTED;
                end else if (mem_busy_s) begin
                    state_d = MEMWAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEMWAIT: begin
                if (advance_s && bus.mm_halt) begin
                    state_d = HALTED;
                end else if (bus.dhit || dmem_done_q) begin
                    state_d = RUN;
                end else begin
                    state_d = MEMWAIT;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (advance_s) begin
            dmem_done_d = 1'b0;
        end else if (bus.dhit) begin
            dmem_done_d = 1'b1;
        end else begin
            dmem_done_d = dmem_done_q;
        end

        if (advance_s && bus.mm_halt) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_q;
        end

        if (!halted_s && (!advance_s || bubble_s) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (redirect_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            dmem_done_q <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            dmem_done_q <= dmem_done_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; inputs change on the falling
// edge, combinational outputs are checked 1 time unit later, state at the next falling edge.
module tb_pipeline_ctrl;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;

    localparam logic [31:0] ST_RUN     = 32'd0;
    localparam logic [31:0] ST_MEMWAIT = 32'd1;
    localparam logic [31:0] EN_ALL     = 32'h1f;
    localparam logic [31:0] EN_BUBBLE  = 32'h07;
    localparam logic [31:0] FL_ALL     = 32'h7;
    localparam logic [31:0] FL_IDEX    = 32'h2;

    pipeline_ctrl_if #(.CNT_W(32)) bus_if ();

    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus_if.master)
    );

    logic [31:0] en_w;
    logic [31:0] fl_w;
    assign en_w = {27'd0, bus_if.pc_en, bus_if.ifid_en, bus_if.idex_en,
                   bus_if.exmm_en, bus_if.mmwb_en};
    assign fl_w = {29'd0, bus_if.ifid_flush, bus_if.idex_flush, bus_if.exmm_flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        bus_if.ihit        = 1'b0;
        bus_if.dhit        = 1'b0;
        bus_if.mm_dREN     = 1'b0;
        bus_if.mm_dWEN     = 1'b0;
        bus_if.mm_halt     = 1'b0;
        bus_if.mm_redirect = 1'b0;
        bus_if.ex_memread  = 1'b0;
        bus_if.ex_rd       = 5'd0;
        bus_if.id_rs       = 5'd0;
        bus_if.id_rt       = 5'd0;
    endtask

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        clr_inputs();

        // Reset state
        #1;
        chk("rst_en", en_w, 32'h0);
        chk("rst_fl", fl_w, 32'h0);
        chk("rst_halt", {31'd0, bus_if.halt}, 32'd0);
        chk("rst_stall", bus_if.stall_cnt, 32'd0);
        chk("rst_flushcnt", bus_if.flush_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running pipe, no hazards
        bus_if.ihit = 1'b1;
        #1;
        chk("run_en", en_w, EN_ALL);
        chk("run_fl", fl_w, 32'h0);
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("run_stall", bus_if.stall_cnt, 32'd0);
        chk("run_flushcnt", bus_if.flush_cnt, 32'd0);
        chk("run_halt", {31'd0, bus_if.halt}, 32'd0);

        // Load miss held for three cycles
        bus_if.mm_dREN = 1'b1;
        #1;
        chk("ld_en0", en_w, 32'h0);
        chk("ld_dren", {31'd0, bus_if.dREN_out}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ld_state_wait", {30'd0, dut.state_q}, ST_MEMWAIT);
            chk("ld_en_hold", en_w, 32'h0);
        end
        chk("ld_stall3", bus_if.stall_cnt, 32'd3);
        bus_if.dhit = 1'b1;
        #1;
        chk("ld_adv_en", en_w, EN_ALL);
        @(negedge clk);
        chk("ld_state_run", {30'd0, dut.state_q}, ST_RUN);
        chk("ld_stall_after", bus_if.stall_cnt, 32'd3);
        chk("ld_done_clr", {31'd0, dut.dmem_done_q}, 32'd0);
        clr_inputs();

        // Store completes while the icache misses
        bus_if.mm_dWEN = 1'b1;
        bus_if.dhit    = 1'b1;
        #1;
        chk("st_dwen", {31'd0, bus_if.dWEN_out}, 32'd1);
        chk("st_en0", en_w, 32'h0);
        @(negedge clk);
        bus_if.dhit = 1'b0;
        #1;
        chk("st_dwen_drop", {31'd0, bus_if.dWEN_out}, 32'd0);
        chk("st_done_set", {31'd0, dut.dmem_done_q}, 32'd1);
        chk("st_en_hold", en_w, 32'h0);
        @(negedge clk);
        bus_if.ihit = 1'b1;
        #1;
        chk("st_no_reissue", {31'd0, bus_if.dWEN_out}, 32'd0);
        chk("st_adv_en", en_w, EN_ALL);
        @(negedge clk);
        chk("st_done_clr", {31'd0, dut.dmem_done_q}, 32'd0);
        chk("st_stall", bus_if.stall_cnt, 32'd5);
        clr_inputs();

        // Load-use on rt
        bus_if.ihit       = 1'b1;
        bus_if.ex_memread = 1'b1;
        bus_if.ex_rd      = 5'd5;
        bus_if.id_rt      = 5'd5;
        #1;
        chk("lu_en", en_w, EN_BUBBLE);
        chk("lu_fl", fl_w, FL_IDEX);
        @(negedge clk);
        chk("lu_stall", bus_if.stall_cnt, 32'd6);

        // r0 destination never stalls
        bus_if.ex_rd = 5'd0;
        bus_if.id_rs = 5'd0;
        #1;
        chk("lu_r0_en", en_w, EN_ALL);
        @(negedge clk);
        chk("lu_r0_stall", bus_if.stall_cnt, 32'd6);

        // Load-use on rs
        bus_if.ex_rd = 5'd7;
        bus_if.id_rs = 5'd7;
        bus_if.id_rt = 5'd3;
        #1;
        chk("lu_rs_en", en_w, EN_BUBBLE);
        @(negedge clk);
        chk("lu_rs_stall", bus_if.stall_cnt, 32'd7);

        // Redirect overrides load-use
        bus_if.ex_rd       = 5'd5;
        bus_if.id_rt       = 5'd5;
        bus_if.mm_redirect = 1'b1;
        #1;
        chk("rd_en", en_w, EN_ALL);
        chk("rd_fl", fl_w, FL_ALL);
        @(negedge clk);
        chk("rd_flushcnt", bus_if.flush_cnt, 32'd1);
        chk("rd_stall", bus_if.stall_cnt, 32'd7);

        // Redirect without ihit is only a stall
        bus_if.ihit = 1'b0;
        #1;
        chk("rd_hold_fl", fl_w, 32'h0);
        @(negedge clk);
        chk("rd_hold_flushcnt", bus_if.flush_cnt, 32'd1);
        chk("rd_hold_stall", bus_if.stall_cnt, 32'd8);
        clr_inputs();

        // Halt waits for advance
        bus_if.mm_halt = 1'b1;
        @(negedge clk);
        chk("ht_wait_halt", {31'd0, bus_if.halt}, 32'd0);
        chk("ht_wait_state", {30'd0, dut.state_q}, ST_RUN);
        chk("ht_wait_stall", bus_if.stall_cnt, 32'd9);
        bus_if.ihit = 1'b1;
        #1;
        chk("ht_adv_en", en_w, EN_ALL);
        @(negedge clk);
        bus_if.mm_halt = 1'b0;
        bus_if.mm_dREN = 1'b1;
        #1;
        chk("ht_halt", {31'd0, bus_if.halt}, 32'd1);
        chk("ht_en0", en_w, 32'h0);
        chk("ht_dren0", {31'd0, bus_if.dREN_out}, 32'd0);
        @(negedge clk);
        chk("ht_sticky", {31'd0, bus_if.halt}, 32'd1);
        chk("ht_stall_frozen", bus_if.stall_cnt, 32'd9);

        // Asynchronous reset while halted
        clr_inputs();
        bus_if.ihit = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_halt", {31'd0, bus_if.halt}, 32'd0);
        chk("ar_state", {30'd0, dut.state_q}, ST_RUN);
        chk("ar_stall", bus_if.stall_cnt, 32'd0);
        chk("ar_flushcnt", bus_if.flush_cnt, 32'd0);
        chk("ar_en", en_w, EN_ALL);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_en", en_w, EN_ALL);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
